// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit add/subtract unit built as a ripple of STAGES equal slices,
//   one slice per pipeline stage, with the carry registered between stages.
//   A single global stall (adv) moves every stage forward together, so the
//   valid/ready handshake on both ends behaves like a STAGES-deep skid-free
//   pipeline: when the output beat is not taken, nothing moves.
//
//   Stage k register contents:
//     valid_reg  - beat/bubble marker
//     a_reg      - operand a (upper slices still to be consumed)
//     b_reg      - effective operand b (already inverted for subtract)
//     sum_reg    - result slices 0..k, upper slices zero
//     carry_reg  - carry out of slice k
//   The last stage additionally holds the signed-overflow flag.
//
//   WIDTH must be >= 2, STAGES must divide WIDTH and lie in 1..WIDTH.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  // Global advance: the whole pipe moves unless a finished beat is waiting
  // on a consumer that is not ready.
  logic adv;

  // Operand preparation at the pipe entry: subtract is a + ~b + 1.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    // Values presented by the predecessor (the inputs for stage 0).
    logic             src_valid;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_carry;

    // This stage's registered state.
    logic             valid_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;

    // Combinational slice adder and the updated partial result.
    logic [SLICE:0]   slice_add;
    logic [WIDTH-1:0] sum_next;

    if (gi == 0) begin : g_src_in
      assign src_valid = in_valid;
      assign src_a     = a;
      assign src_b     = b_eff;
      assign src_sum   = '0;
      assign src_carry = c0;
    end else begin : g_src_prev
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_a     = g_stage[gi-1].a_reg;
      assign src_b     = g_stage[gi-1].b_reg;
      assign src_sum   = g_stage[gi-1].sum_reg;
      assign src_carry = g_stage[gi-1].carry_reg;
    end

    // Add slice gi of both operands plus the carry arriving from below.
    assign slice_add = {1'b0, src_a[gi*SLICE +: SLICE]}
                     + {1'b0, src_b[gi*SLICE +: SLICE]}
                     + (SLICE+1)'(src_carry);

    // Splice the fresh slice into the lower slices computed earlier.
    always_comb begin
      sum_next                    = src_sum;
      sum_next[gi*SLICE +: SLICE] = slice_add[SLICE-1:0];
    end

    // Stage register: valid always follows on adv; payload only for real
    // beats so bubbles leave the last data untouched.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_reg <= 1'b0;
        a_reg     <= '0;
        b_reg     <= '0;
        sum_reg   <= '0;
        carry_reg <= 1'b0;
      end else if (adv) begin
        valid_reg <= src_valid;
        if (src_valid) begin
          a_reg     <= src_a;
          b_reg     <= src_b;
          sum_reg   <= sum_next;
          carry_reg <= slice_add[SLICE];
        end
      end
    end

    if (gi == STAGES - 1) begin : g_msb
      // Carry into the MSB recovered from the MSB sum bit and its operands.
      logic c_msb;
      logic ovf_reg;

      assign c_msb = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ slice_add[SLICE-1];

      // Signed overflow flag, registered alongside the final slice.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ovf_reg <= 1'b0;
        end else if (adv && src_valid) begin
          ovf_reg <= c_msb ^ slice_add[SLICE];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].carry_reg;
  assign ovf       = g_stage[STAGES-1].g_msb.ovf_reg;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder
//   Main instance WIDTH=8/STAGES=2 exercised through reset, directed,
//   streaming and backpressure scenarios against a FIFO-of-results model;
//   four more instances (8/1, 8/8, 16/4, 32/2) run a random vector sweep
//   with exact latency checking. Expected results come from plain integer
//   arithmetic on the operands.
module tb_pipelined_adder;

  localparam int DUT_W   = 8;
  localparam int DUT_S   = 2;
  localparam int SWEEP_N = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [DUT_W-1:0] a;
  logic [DUT_W-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [DUT_W-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  pipelined_adder #(.WIDTH(DUT_W), .STAGES(DUT_S)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  // sweep instances share one 32-bit stimulus, truncated per width
  logic        sw_valid;
  logic [31:0] sw_a;
  logic [31:0] sw_b;
  logic        sw_cin;
  logic        sw_sub;
  logic        sw_irdy [4];
  logic        sw_ovld [4];
  logic        sw_co   [4];
  logic        sw_of   [4];
  logic [7:0]  s_w8a;
  logic [7:0]  s_w8b;
  logic [15:0] s_w16;
  logic [31:0] s_w32;
  logic [31:0] sw_sum  [4];
  int          sw_width  [4] = '{8, 8, 16, 32};
  int          sw_stages [4] = '{1, 8, 4, 2};

  assign sw_sum[0] = {24'd0, s_w8a};
  assign sw_sum[1] = {24'd0, s_w8b};
  assign sw_sum[2] = {16'd0, s_w16};
  assign sw_sum[3] = s_w32;

  pipelined_adder #(.WIDTH(8), .STAGES(1)) u_sw0 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_irdy[0]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovld[0]),
    .out_ready(1'b1), .sum(s_w8a), .cout(sw_co[0]), .ovf(sw_of[0])
  );
  pipelined_adder #(.WIDTH(8), .STAGES(8)) u_sw1 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_irdy[1]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovld[1]),
    .out_ready(1'b1), .sum(s_w8b), .cout(sw_co[1]), .ovf(sw_of[1])
  );
  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_sw2 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_irdy[2]),
    .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovld[2]),
    .out_ready(1'b1), .sum(s_w16), .cout(sw_co[2]), .ovf(sw_of[2])
  );
  pipelined_adder #(.WIDTH(32), .STAGES(2)) u_sw3 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(sw_irdy[3]),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(sw_ovld[3]),
    .out_ready(1'b1), .sum(s_w32), .cout(sw_co[3]), .ovf(sw_of[3])
  );

  // expected result of one accepted beat, in acceptance order
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } exp_t;

  exp_t q[$];

  logic [31:0] hist_a   [SWEEP_N];
  logic [31:0] hist_b   [SWEEP_N];
  logic        hist_cin [SWEEP_N];
  logic        hist_sub [SWEEP_N];

  // Arithmetic reference: unsigned result/carry and signed range overflow.
  function automatic void ref_model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                    input logic ci, input logic si,
                                    output logic [31:0] s, output logic co, output logic ov);
    longint unsigned modv, am, bm, r;
    longint          half, sa, sb, sr;
    modv = 64'd1 << w;
    am   = 64'(ai) % modv;
    bm   = 64'(bi) % modv;
    half = longint'(modv / 2);
    if (si) begin
      r  = am + modv - bm;
      co = (am >= bm);
    end else begin
      r  = am + bm + 64'(ci);
      co = (r >= modv);
    end
    s  = 32'(r % modv);
    sa = (am >= modv / 2) ? longint'(am) - longint'(modv) : longint'(am);
    sb = (bm >= modv / 2) ? longint'(bm) - longint'(modv) : longint'(bm);
    sr = si ? (sa - sb) : (sa + sb + longint'(ci));
    ov = (sr >= half) || (sr < -half);
  endfunction

  function automatic exp_t make_exp(input logic [7:0] ai, input logic [7:0] bi,
                                    input logic ci, input logic si);
    exp_t        e;
    logic [31:0] s32;
    logic        co, ov;
    ref_model(8, {24'd0, ai}, {24'd0, bi}, ci, si, s32, co, ov);
    e.a = ai; e.b = bi; e.cin = ci; e.sub = si;
    e.s = s32[7:0]; e.co = co; e.ov = ov;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf} !== 11'd0)
      $display("FAIL reset_state: got valid=%b sum=%h cout=%b ovf=%b, required all 0", out_valid, sum, cout, ovf);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    if ({out_valid, sum, cout, ovf} !== 11'd0) errors++;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_in_ready: got %b, required 1", in_ready);
    end
    // two beats in flight, then async reset between edges
    in_valid = 1'b1; a = 8'h12; b = 8'h34;
    @(negedge clk);
    a = 8'h50; b = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h46) begin
      errors++;
      $display("FAIL inflight_head: got valid=%b sum=%h, required valid=1 sum=46", out_valid, sum);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b sum=%h cout=%b ovf=%b, required all 0", out_valid, sum, cout, ovf);
    end
    $display("reset: async reset with 2 beats in flight -> valid=%b sum=%h", out_valid, sum);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_beat: cycle %0d got out_valid=%b, required 0", c, out_valid);
      end
    end
  endtask

  task automatic test_carry_boundary();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; a = 8'hFF; b = 8'h01; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL carry_latency_early: got out_valid=%b one cycle after accept, required 0", out_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf} !== {1'b1, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL carry_boundary: got valid=%b sum=%h cout=%b ovf=%b, required 1 00 1 0", out_valid, sum, cout, ovf);
    end
    $display("carry: FF+01 -> sum=%h cout=%b ovf=%b", sum, cout, ovf);
  endtask

  task automatic test_overflow_subtract();
    logic [7:0] ta  [3] = '{8'h7F, 8'h05, 8'h80};
    logic [7:0] tb  [3] = '{8'h01, 8'h07, 8'h01};
    logic       ts  [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] es  [3] = '{8'h80, 8'hFE, 8'h7F};
    logic       eco [3] = '{1'b0, 1'b0, 1'b1};
    logic       eov [3] = '{1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = ta[i]; b = tb[i]; cin = 1'b1; sub = ts[i];
      if (!ts[i]) cin = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({out_valid, sum, cout, ovf} !== {1'b1, es[i], eco[i], eov[i]}) begin
        errors++;
        $display("FAIL ovf_sub_%0d: got valid=%b sum=%h cout=%b ovf=%b, required 1 %h %b %b",
                 i, out_valid, sum, cout, ovf, es[i], eco[i], eov[i]);
      end
      $display("ovf/sub %0d: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b", i, ta[i], tb[i], ts[i], sum, cout, ovf);
    end
  endtask

  task automatic test_streaming();
    exp_t e;
    bit   exp_ready;
    int   got = 0;
    q.delete();
    for (int c = 0; c < 16 + DUT_S + 1; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (c < 16);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      #1;
      exp_ready = !out_valid || out_ready;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL stream_in_ready: cycle %0d got %b, required %b", c, in_ready, exp_ready);
      end
      checks++;
      if (out_valid !== (c >= DUT_S && c < 16 + DUT_S)) begin
        errors++;
        $display("FAIL stream_rate: cycle %0d got out_valid=%b, required %b", c, out_valid, (c >= DUT_S && c < 16 + DUT_S));
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: cycle %0d got unexpected result sum=%h, required no output", c, sum);
        end else begin
          e = q.pop_front();
          got++;
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            errors++;
            $display("FAIL stream_data: got sum=%h cout=%b ovf=%b, required %h %b %b", sum, cout, ovf, e.s, e.co, e.ov);
          end
          $display("stream: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.cin, e.sub, sum, cout, ovf);
        end
      end
      if (in_valid && exp_ready) q.push_back(make_exp(a, b, cin, sub));
    end
    checks++;
    if (got != 16 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: got %0d results (%0d pending), required 16 (0 pending)", got, q.size());
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t       e;
    bit         exp_ready;
    int         got = 0;
    int         sent = 0;
    logic [7:0] hold_sum;
    logic       hold_cout, hold_ovf;
    q.delete();
    hold_sum = '0; hold_cout = 1'b0; hold_ovf = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(c >= 8 && c < 13);
      in_valid  = (c < 25);
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      #1;
      exp_ready = !out_valid || out_ready;
      checks++;
      if (in_ready !== exp_ready) begin
        errors++;
        $display("FAIL bp_in_ready: cycle %0d got %b, required %b", c, in_ready, exp_ready);
      end
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          errors++;
          $display("FAIL bp_stall: cycle %0d got in_ready=%b out_valid=%b, required 0 1", c, in_ready, out_valid);
        end
        checks++;
        if (c == 8) begin
          hold_sum = sum; hold_cout = cout; hold_ovf = ovf;
          if (q.size() != DUT_S) begin
            errors++;
            $display("FAIL bp_occupancy: got %0d beats held, required %0d", q.size(), DUT_S);
          end
        end else if ({sum, cout, ovf} !== {hold_sum, hold_cout, hold_ovf}) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d got sum=%h cout=%b ovf=%b, required %h %b %b",
                   c, sum, cout, ovf, hold_sum, hold_cout, hold_ovf);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: cycle %0d got unexpected result sum=%h, required no output", c, sum);
        end else begin
          e = q.pop_front();
          got++;
          if ({sum, cout, ovf} !== {e.s, e.co, e.ov}) begin
            errors++;
            $display("FAIL bp_data: got sum=%h cout=%b ovf=%b, required %h %b %b", sum, cout, ovf, e.s, e.co, e.ov);
          end
          $display("backpressure: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b ovf=%b", e.a, e.b, e.cin, e.sub, sum, cout, ovf);
        end
      end
      if (in_valid && exp_ready) begin
        q.push_back(make_exp(a, b, cin, sub));
        sent++;
      end
    end
    checks++;
    if (q.size() != 0 || got != sent) begin
      errors++;
      $display("FAIL bp_drain: got %0d results for %0d beats, required equal with none pending", got, sent);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_sweep();
    int          inst_err [4] = '{0, 0, 0, 0};
    logic [31:0] es;
    logic        eco, eov, exp_v;
    int          k;
    for (int j = 0; j < SWEEP_N + 9; j++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        exp_v = (j >= sw_stages[i]) && (j - sw_stages[i] < SWEEP_N);
        checks++;
        if (sw_ovld[i] !== exp_v) begin
          errors++; inst_err[i]++;
          $display("FAIL sweep_latency_%0d/%0d: cycle %0d got out_valid=%b, required %b",
                   sw_width[i], sw_stages[i], j, sw_ovld[i], exp_v);
        end else if (exp_v) begin
          k = j - sw_stages[i];
          ref_model(sw_width[i], hist_a[k], hist_b[k], hist_cin[k], hist_sub[k], es, eco, eov);
          checks++;
          if ({sw_sum[i], sw_co[i], sw_of[i]} !== {es, eco, eov}) begin
            errors++; inst_err[i]++;
            $display("FAIL sweep_data_%0d/%0d: a=%h b=%h cin=%b sub=%b got sum=%h cout=%b ovf=%b, required %h %b %b",
                     sw_width[i], sw_stages[i], hist_a[k], hist_b[k], hist_cin[k], hist_sub[k],
                     sw_sum[i], sw_co[i], sw_of[i], es, eco, eov);
          end
        end
      end
      if (j < SWEEP_N) begin
        case (j)
          0:       begin sw_a = 32'hFFFF_FFFF; sw_b = 32'd1; sw_cin = 1'b0; sw_sub = 1'b0; end
          1:       begin sw_a = 32'd0; sw_b = 32'd0; sw_cin = 1'b0; sw_sub = 1'b1; end
          2:       begin sw_a = 32'd0; sw_b = 32'd1; sw_cin = 1'b1; sw_sub = 1'b1; end
          3:       begin sw_a = 32'hFFFF_FFFF; sw_b = 32'hFFFF_FFFF; sw_cin = 1'b1; sw_sub = 1'b0; end
          default: begin sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom); end
        endcase
        hist_a[j] = sw_a; hist_b[j] = sw_b; hist_cin[j] = sw_cin; hist_sub[j] = sw_sub;
        sw_valid = 1'b1;
      end else begin
        sw_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++)
      $display("sweep WIDTH=%0d STAGES=%0d: %0d vectors, %0d errors", sw_width[i], sw_stages[i], SWEEP_N, inst_err[i]);
  endtask

  initial begin
    test_reset();
    test_carry_boundary();
    test_overflow_subtract();
    test_streaming();
    test_backpressure();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion before it");
    $fatal(1, "watchdog expired");
  end

endmodule
